tilt_box_draw: RTL and testbench

- Frame-buffer draw source that renders a BOX_W x BOX_H rectangle (solid border, optionally hollow) into the frame manager once per frame.
- Box position moves each frame from the parsed tilt inputs (amount/direction per axis), clamped to the screen.
- Sits upstream of the frame manager on the shared write bus, alongside the background and starfield sources.

---
 rtl/tilt_box_draw.sv | 153 +++++++++++++++
 tb/tb_tilt_box_draw.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilt_box_draw.sv
// Draw source: renders a tilt-steered BOX_W x BOX_H rectangle onto the shared
// frame-manager write bus once per frame, clamped to the screen.
module tilt_box_draw #(
  parameter int unsigned SOURCE_ID        = 3,
  parameter int unsigned SOURCE_SEL_ADDRW = 2,
  parameter int unsigned COLOR_DEPTH      = 9,
  parameter int unsigned SCREEN_W         = 640,
  parameter int unsigned SCREEN_H         = 480,
  parameter int unsigned BOX_W            = 32,
  parameter int unsigned BOX_H            = 32,
  parameter int unsigned INIT_X           = 304,
  parameter int unsigned INIT_Y           = 224,
  parameter logic [COLOR_DEPTH-1:0] BORDER_COLOR = 9'b111000000,
  parameter logic [COLOR_DEPTH-1:0] FILL_COLOR   = 9'b000111000,
  parameter bit          HOLLOW           = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame,
  input  logic [3:0]                  tilt_amount_x,
  input  logic                        tilt_direction_x,
  input  logic [3:0]                  tilt_amount_y,
  input  logic                        tilt_direction_y,
  input  logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  input  logic                        write_awaited,
  output logic                        write_active,
  output logic [31:0]                 write_x_addr,
  output logic [31:0]                 write_y_addr,
  output logic [COLOR_DEPTH-1:0]      write_color_data,
  output logic                        write_transparent,
  output logic                        frame_overrun
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned COL_W = $clog2(BOX_W);
  localparam int unsigned ROW_W = $clog2(BOX_H);
  localparam logic [POS_W-1:0] MAX_X = POS_W'(SCREEN_W - BOX_W);
  localparam logic [POS_W-1:0] MAX_Y = POS_W'(SCREEN_H - BOX_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_GRANT,
    S_DRAW,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_x_q, pos_x_d;
  logic [POS_W-1:0]  pos_y_q, pos_y_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              overrun_q, overrun_d;

  logic owned, drawing, accept, last_col, last_row, border;

  // Signed 12-bit step, saturated to [0, lim].
  function automatic logic [POS_W-1:0] clamp_step(input logic [POS_W-1:0] pos,
                                                  input logic [3:0]       amt,
                                                  input logic             dir,
                                                  input logic [POS_W-1:0] lim);
    logic signed [POS_W-1:0] sum;
    logic [POS_W-1:0]        res;
    sum = dir ? $signed(pos + POS_W'(amt)) : $signed(pos - POS_W'(amt));
    if (sum < 0)                 res = '0;
    else if (sum > $signed(lim)) res = lim;
    else                         res = sum;
    return res;
  endfunction

  assign owned    = (write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));
  assign drawing  = owned && (state_q == S_DRAW);
  assign accept   = drawing && write_awaited;
  assign last_col = (col_q == COL_W'(BOX_W - 1));
  assign last_row = (row_q == ROW_W'(BOX_H - 1));
  assign border   = (col_q == '0) || (row_q == '0) || last_col || last_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pos_x_q   <= POS_W'(INIT_X);
      pos_y_q   <= POS_W'(INIT_Y);
      col_q     <= '0;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      col_q     <= col_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    col_d     = col_q;
    row_d     = row_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (frame) state_d = S_MOVE;
      end
      S_MOVE: begin
        pos_x_d = clamp_step(pos_x_q, tilt_amount_x, tilt_direction_x, MAX_X);
        pos_y_d = clamp_step(pos_y_q, tilt_amount_y, tilt_direction_y, MAX_Y);
        col_d   = '0;
        row_d   = '0;
        state_d = S_GRANT;
      end
      S_GRANT: begin
        if (frame) overrun_d = 1'b1;
        if (owned) state_d = S_DRAW;
      end
      S_DRAW: begin
        if (frame) overrun_d = 1'b1;
        // Raster walk: advance only on an accepted pixel so losing the bus just pauses.
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) state_d = S_DONE;
            else          row_d   = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are forced to zero when another source owns the OR bus.
  always_comb begin
    write_active      = 1'b0;
    write_x_addr      = '0;
    write_y_addr      = '0;
    write_color_data  = '0;
    write_transparent = 1'b0;
    if (drawing) begin
      write_active      = 1'b1;
      write_x_addr      = 32'(pos_x_q) + 32'(col_q);
      write_y_addr      = 32'(pos_y_q) + 32'(row_q);
      write_color_data  = border ? BORDER_COLOR : FILL_COLOR;
      write_transparent = border ? 1'b0 : HOLLOW;
    end
  end

  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_tilt_box_draw.sv
// Scoreboard bench for tilt_box_draw: stimulus queues expected pixels, a
// negedge monitor compares every presented pixel of a solid and a hollow DUT.
module tb_tilt_box_draw;

  localparam logic [8:0] BORDER = 9'b111000000;
  localparam logic [8:0] FILL   = 9'b000111000;

  typedef struct {
    int         x;
    int         y;
    logic [8:0] color;
    bit         interior;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, frame;
  logic [3:0]  amt_x, amt_y;
  logic        dir_x, dir_y;
  logic [1:0]  sel;
  logic        awaited;

  logic        active, transp, overrun;
  logic [31:0] xa, ya;
  logic [8:0]  color;
  logic        h_active, h_transp, h_overrun;
  logic [31:0] h_xa, h_ya;
  logic [8:0]  h_color;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   px = 304;
  int   py = 224;

  always #20 clk = ~clk;

  tilt_box_draw dut (
    .clk(clk), .reset(reset), .frame(frame),
    .tilt_amount_x(amt_x), .tilt_direction_x(dir_x),
    .tilt_amount_y(amt_y), .tilt_direction_y(dir_y),
    .write_source_sel(sel), .write_awaited(awaited),
    .write_active(active), .write_x_addr(xa), .write_y_addr(ya),
    .write_color_data(color), .write_transparent(transp),
    .frame_overrun(overrun)
  );

  tilt_box_draw #(.HOLLOW(1'b1)) dut_h (
    .clk(clk), .reset(reset), .frame(frame),
    .tilt_amount_x(amt_x), .tilt_direction_x(dir_x),
    .tilt_amount_y(amt_y), .tilt_direction_y(dir_y),
    .write_source_sel(sel), .write_awaited(awaited),
    .write_active(h_active), .write_x_addr(h_xa), .write_y_addr(h_ya),
    .write_color_data(h_color), .write_transparent(h_transp),
    .frame_overrun(h_overrun)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] pack_px(input int x, input int y, input logic [8:0] c, input logic t);
    return {22'd0, 32'(x), 32'(y), c, t};
  endfunction

  function automatic int step(input int p, input int a, input bit d, input int mx);
    int n;
    n = d ? p + a : p - a;
    if (n < 0) n = 0;
    if (n > mx) n = mx;
    return n;
  endfunction

  // Monitor: compares whatever the DUTs present against the queue front.
  always @(negedge clk) begin
    if (!reset) begin
      if (sel != 2'd3) begin
        check("bus_zero", 96'({active, xa, ya, color, transp}), 96'd0);
        check("bus_zero_h", 96'({h_active, h_xa, h_ya, h_color, h_transp}), 96'd0);
      end else if (active) begin
        if (q.size() == 0) begin
          check("unexpected_px", pack_px(int'(xa), int'(ya), color, transp), 96'd0);
        end else begin
          check("pixel", pack_px(int'(xa), int'(ya), color, transp),
                pack_px(q[0].x, q[0].y, q[0].color, 1'b0));
          check("pixel_hollow", pack_px(int'(h_xa), int'(h_ya), h_color, h_transp),
                pack_px(q[0].x, q[0].y, q[0].color, q[0].interior));
          if (awaited) void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    px = step(px, int'(amt_x), dir_x, 640 - 32);
    py = step(py, int'(amt_y), dir_y, 480 - 32);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        exp_t e;
        bit   b;
        b = (r == 0) || (r == 31) || (c == 0) || (c == 31);
        e.x = px + c;
        e.y = py + r;
        e.color = b ? BORDER : FILL;
        e.interior = !b;
        q.push_back(e);
      end
    end
  endtask

  task automatic pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 96'(q.size()), 96'd0);
      q.delete();
    end
    tick();
    check("idle_after_draw", 96'(active), 96'd0);
  endtask

  // Frame with latency and hand-computed first-pixel checks.
  task automatic start_frame(input int ex, input int ey);
    push_frame();
    pulse();
    check("lat_move", 96'(active), 96'd0);
    tick();
    check("lat_grant", 96'(active), 96'd0);
    tick();
    check("lat_draw", 96'(active), 96'd1);
    check("first_px", {32'd0, xa, ya}, {32'd0, 32'(ex), 32'(ey)});
  endtask

  task automatic run_frame();
    push_frame();
    pulse();
    wait_drain(1200);
  endtask

  initial begin
    reset = 1'b1; frame = 1'b0; amt_x = 4'd0; amt_y = 4'd0;
    dir_x = 1'b0; dir_y = 1'b0; sel = 2'd3; awaited = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_active", 96'({active, h_active}), 96'd0);
    check("reset_overrun", 96'({overrun, h_overrun}), 96'd0);
    check("reset_bus", 96'({xa, ya, color, transp}), 96'd0);

    // Basic draw at INIT, no tilt; last pixel (335,255) covered by the scoreboard.
    start_frame(304, 224);
    wait_drain(1200);

    // Lose the bus at pixel (col 7, row 3), then resume at the same pixel.
    push_frame();
    pulse();
    begin
      int n = 0;
      while (q.size() > 1024 - (3 * 32 + 7) && n < 1200) begin
        tick();
        n++;
      end
    end
    sel = 2'd1;
    repeat (10) tick();
    sel = 2'd3;
    #1;
    check("resume_px", {32'd0, xa, ya}, {32'd0, 32'd311, 32'd227});
    wait_drain(1200);

    // Back-pressure: awaited toggles every cycle.
    push_frame();
    pulse();
    begin
      int n = 0;
      while (q.size() != 0 && n < 3000) begin
        awaited = ~awaited;
        tick();
        n++;
      end
    end
    awaited = 1'b1;
    wait_drain(10);

    // Tilt +5 x, -3 y.
    amt_x = 4'd5; dir_x = 1'b1; amt_y = 4'd3; dir_y = 1'b0;
    start_frame(309, 221);
    wait_drain(1200);

    // Frame pulse mid-draw: sticky overrun, draw unchanged.
    amt_x = 4'd0; amt_y = 4'd0;
    check("overrun_pre", 96'(overrun), 96'd0);
    push_frame();
    pulse();
    repeat (100) tick();
    pulse();
    check("overrun_set", 96'({overrun, h_overrun}), 96'b11);
    wait_drain(1200);
    check("overrun_sticky", 96'(overrun), 96'd1);

    // Clamp at the left edge, then at the right edge.
    amt_x = 4'd15; dir_x = 1'b0;
    for (int i = 0; i < 21; i++) run_frame();
    start_frame(0, 221);
    wait_drain(1200);
    dir_x = 1'b1;
    for (int i = 0; i < 41; i++) run_frame();
    start_frame(608, 221);
    wait_drain(1200);

    // Reset mid-draw, then frame coincident with reset.
    amt_x = 4'd0;
    push_frame();
    pulse();
    repeat (50) tick();
    reset = 1'b1;
    q.delete();
    px = 304;
    py = 224;
    tick();
    check("reset_mid_active", 96'(active), 96'd0);
    check("reset_mid_overrun", 96'(overrun), 96'd0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_wins", 96'(active), 96'd0);
    end
    start_frame(304, 224);
    wait_drain(1200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
